// File: rtl/totient_sequencer.sv
// totient_sequencer: walks n = 1..N_MAX, counts k in 1..n with gcd(n,k)==1 by repeated subtraction,
// publishes phi(n) on a registered bus and a hex 7-segment digit. Optional is_prime output under TOTIENT_PRIME_FLAG_EN.
module totient_sequencer #(
    parameter int WIDTH = 4,
    parameter int N_MAX = 15,
    parameter int DWELL = 0
) (
    input  logic             clk_0,
    input  logic             R,
    input  logic             run,
    output logic [WIDTH-1:0] n_out,
    output logic [WIDTH-1:0] phi_out,
    output logic             phi_valid,
    output logic             busy,
    output logic             wrap,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             E,
    output logic             F,
    output logic             G
`ifdef TOTIENT_PRIME_FLAG_EN
    ,
    output logic             is_prime
`endif
);
    localparam int DW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [DW-1:0] DWELL_V = DW'(DWELL);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(N_MAX);

    typedef enum logic [2:0] {IDLE, LOAD, GCD, ACC, SHOW} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d, k_q, k_d, cnt_q, cnt_d, a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] n_out_q, n_out_d, phi_q, phi_d, cnt_inc;
    logic             valid_q, valid_d, wrap_q, wrap_d, seen_q, seen_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [6:0]       seg;
`ifdef TOTIENT_PRIME_FLAG_EN
    logic             prime_q, prime_d;
`endif

    // a_q holds the gcd once the subtraction loop has converged
    assign cnt_inc = cnt_q + WIDTH'(a_q == ONE);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        n_out_d = n_out_q;
        phi_d   = phi_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        seen_d  = seen_q;
        dwell_d = dwell_q;
`ifdef TOTIENT_PRIME_FLAG_EN
        prime_d = prime_q;
`endif
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = LOAD;
                    k_d     = ONE;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                a_d     = n_q;
                b_d     = k_q;
                state_d = GCD;
            end
            GCD: begin
                if (a_q == b_q) state_d = ACC;
                else if (a_q > b_q) a_d = a_q - b_q;
                else b_d = b_q - a_q;
            end
            ACC: begin
                cnt_d = cnt_inc;
                if (k_q < n_q) begin
                    k_d     = k_q + ONE;
                    state_d = LOAD;
                end else begin
                    state_d = SHOW;
                    phi_d   = cnt_inc;
                    n_out_d = n_q;
                    valid_d = 1'b1;
                    wrap_d  = (n_q == ONE) && seen_q;
                    seen_d  = 1'b1;
                    dwell_d = '0;
`ifdef TOTIENT_PRIME_FLAG_EN
                    prime_d = (n_q > ONE) && (cnt_inc == n_q - ONE);
`endif
                end
            end
            SHOW: begin
                if (dwell_q == DWELL_V) begin
                    n_d     = (n_q == LAST) ? ONE : n_q + ONE;
                    k_d     = ONE;
                    cnt_d   = '0;
                    state_d = run ? LOAD : IDLE;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_0 or posedge R) begin
        if (R) begin
            state_q <= IDLE;
            n_q     <= ONE;
            k_q     <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            n_out_q <= ONE;
            phi_q   <= ONE;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            seen_q  <= 1'b0;
            dwell_q <= '0;
`ifdef TOTIENT_PRIME_FLAG_EN
            prime_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_out_q <= n_out_d;
            phi_q   <= phi_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            seen_q  <= seen_d;
            dwell_q <= dwell_d;
`ifdef TOTIENT_PRIME_FLAG_EN
            prime_q <= prime_d;
`endif
        end
    end

    always_comb begin
        case (4'(phi_q))
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
    end

    assign {A, B, C, D, E, F, G} = seg;
    assign n_out     = n_out_q;
    assign phi_out   = phi_q;
    assign phi_valid = valid_q;
    assign wrap      = wrap_q;
    assign busy      = (state_q != IDLE);
`ifdef TOTIENT_PRIME_FLAG_EN
    assign is_prime  = prime_q;
`endif
endmodule

// File: doc/totient_sequencer.md
Name: totient_sequencer

Overview:
- Multi-cycle controller that walks n = 1..N_MAX and computes Euler's totient phi(n).
- For each n it sequences a subtraction-GCD datapath over k = 1..n and counts the k with gcd(n,k) = 1.
- It presents each result on a registered binary bus and on a 7-segment digit A..G, holds it for a programmable dwell, then advances.
- Sits between the board clock/reset and the 7-segment display in the Design Problem top level.

Parameters:
- WIDTH, 4, bit width of n, k, GCD operands and the phi count.
- N_MAX, 15, last n before wrap to 1; must satisfy 1 <= N_MAX <= 2^WIDTH-1.
- DWELL, 0, extra cycles each result is held in SHOW before advancing.

Ports:
- clk_0  input  1  single system clock, rising edge.
- R  input  1  reset, asynchronous, active-high.
- run  input  1  level enable; 1 = keep sequencing.
- n_out  output  WIDTH  n whose phi is currently displayed.
- phi_out  output  WIDTH  phi(n_out), registered.
- phi_valid  output  1  one-cycle pulse when phi_out/n_out update.
- busy  output  1  1 in any state other than IDLE.
- wrap  output  1  one-cycle pulse, coincident with phi_valid, for the first result after n returns to 1.
- A,B,C,D,E,F,G  output  1 each  active-high segments a..g, hex digit of phi_out[3:0].

Behaviour:
- Reset (asynchronous, any state): state=IDLE, n=1, k=0, count=0, n_out=1, phi_out=1, phi_valid=0, wrap=0, busy=0, ABCDEFG=0110000 ("1").
- States: IDLE, LOAD, GCD, ACC, SHOW.
- IDLE: if run=1, go to LOAD next cycle with k=1 and count=0.
- LOAD (1 cycle): a<=n, b<=k; go to GCD.
- GCD (1 cycle per step):
  - a==b: gcd=a, go to ACC.
  - a>b: a<=a-b.
  - else: b<=b-a.
  - All arithmetic is unsigned WIDTH-bit; operands are never 0, so no underflow.
- ACC (1 cycle): count<=count+(gcd==1).
  - k<n: k<=k+1, go to LOAD.
  - k==n: go to SHOW; phi_out<=updated count and n_out<=n on the same edge; pulse phi_valid.
- SHOW: hold for DWELL cycles after the phi_valid cycle (DWELL=0 means leave on the next cycle).
  - On exit: n<=(n==N_MAX)?1:n+1; k<=1; count<=0.
  - run=1: go to LOAD. run=0: go to IDLE, with the already-advanced n retained.
- run deasserted mid-computation: the current n completes through SHOW, then the block enters IDLE. No partial result is ever published.
- wrap: asserted with phi_valid when the published n_out==1 and it was not produced by the first run after reset.
- phi_out/n_out/segments change only on the phi_valid edge; they are stable in all other cycles.
- Segment decode is combinational from phi_out[3:0], standard hex 0-F (0=1111110, 1=0110000, 2=1101101, 4=0110011, 6=1011111, 8=1111111).
- n=1: k=1 gives gcd(1,1)=1, so phi=1.

Optional Feature:
- Macro TOTIENT_PRIME_FLAG_EN.
- Defined: adds output is_prime (1 bit), registered on the phi_valid edge as (n>1 && phi==n-1); reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold R=1 for 3 cycles with run=1 -> phi_out=1, n_out=1, ABCDEFG=0110000, busy=0, no phi_valid. Assert R mid-GCD -> same values immediately, without waiting for a clock edge.
- Defaults, run=1: successive phi_valid pulses give phi_out = 1,1,2,2,4,2,6,4,6,4 for n_out = 1..10, with segments matching each hex digit.
- Wrap: N_MAX=15, run=1 -> after n_out=15/phi=8 (ABCDEFG=1111111), the next pulse has n_out=1, phi_out=1, wrap=1. No wrap pulse on the first n=1 after reset.
- Pause: drop run during GCD of n=7 -> phi_valid for n=7 (phi=6) still occurs, then busy=0. Raise run 20 cycles later -> next pulse is n=8, phi=4.
- Dwell: DWELL=5 -> consecutive phi_valid pulses are at least 5 cycles further apart than with DWELL=0, and outputs stay stable between pulses.
- With TOTIENT_PRIME_FLAG_EN: is_prime = 0,1,1,0,1,0,1,0 for n=1..8.
